// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall bus patterns, controller states and address types for pipe_ctrl
package pipe_ctrl_pkg;
  localparam int STALL_W = 6;
  localparam int INST_ADDR_W = 32;
  typedef logic [STALL_W-1:0] stall_bus_t;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF = 6'b000011;
  localparam stall_bus_t STALL_ID = 6'b000111;
  localparam stall_bus_t STALL_EX = 6'b001111;
  localparam stall_bus_t STALL_MEM = 6'b011111;
  typedef enum logic [1:0] {CTRL_RUN = 2'd0, CTRL_PEND = 2'd1, CTRL_DISCARD = 2'd2} ctrl_state_e;
  function automatic stall_bus_t stall_merge(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
    return r_mem ? STALL_MEM : r_ex ? STALL_EX : r_id ? STALL_ID : r_if ? STALL_IF : STALL_NONE;
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush bus between pipe_ctrl (master) and the pipeline stages (slave); PIPE_CTRL_PERF_EN adds perf counters
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;
  logic req_if;
  logic req_id;
  logic req_ex;
  logic req_mem;
  logic ex_jump;
  inst_addr_t ex_target;
  logic if_busy;
  stall_bus_t stall;
  logic jump;
  inst_addr_t jump_addr;
  logic if_discard;
  logic stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
`endif
  modport master (
    input req_if, req_id, req_ex, req_mem, ex_jump, ex_target, if_busy,
    output stall, jump, jump_addr, if_discard, stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    , perf_stall_cycles, perf_flushes
`endif
  );
  modport slave (
    output req_if, req_id, req_ex, req_mem, ex_jump, ex_target, if_busy,
    input stall, jump, jump_addr, if_discard, stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    , perf_stall_cycles, perf_flushes
`endif
  );
endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// pipe_ctrl_stall_watchdog: saturating count of consecutive stalled cycles with a sticky timeout flag
module pipe_ctrl_stall_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic timeout
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  // clear on any unstalled cycle, otherwise count up and hold at the limit
  always_comb cnt_d = !stalled ? '0 : cnt_q == LIMIT ? cnt_q : cnt_q + CNT_W'(1);
  // flag latches the edge the count reaches the limit and stays until reset
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
    timeout <= rst ? 1'b0 : timeout | (cnt_d == LIMIT);
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stall requests, arbitrates EX redirects around memory stalls and outstanding fetches; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W = 11
) (
  input logic clk,
  input logic rst,
  pipe_ctrl_if.master bus
);
  ctrl_state_e state_q;
  ctrl_state_e state_d;
  inst_addr_t pend_q;
  logic acc_q;
  logic jv;
  logic fire_ex;
  logic fire_pend;
  logic to_pend;
  logic jump_v;
  stall_bus_t stall_v;
  assign jv = bus.ex_jump & ~acc_q & ~rst;
  assign fire_ex = jv & ~bus.req_mem & (state_q != CTRL_PEND);
  assign to_pend = jv & bus.req_mem & (state_q != CTRL_PEND);
  assign fire_pend = (state_q == CTRL_PEND) & ~bus.req_mem & ~rst;
  assign jump_v = fire_ex | fire_pend;
  // state register
  always_ff @(posedge clk) state_q <= rst ? CTRL_RUN : state_d;
  // next state: a redirect lands in DISCARD when a fetch is still in flight
  always_comb state_d = state_q == CTRL_PEND ? (bus.req_mem ? CTRL_PEND : bus.if_busy ? CTRL_DISCARD : CTRL_RUN) :
                        to_pend ? CTRL_PEND :
                        fire_ex ? (bus.if_busy ? CTRL_DISCARD : CTRL_RUN) :
                        (state_q == CTRL_DISCARD && !bus.if_busy) ? CTRL_RUN : state_q;
  // outputs: a direct redirect overrides front-end stalls since those stages are being flushed
  always_comb begin
    stall_v = fire_ex ? (bus.req_ex ? STALL_EX : STALL_NONE) : stall_merge(bus.req_if, bus.req_id, bus.req_ex, bus.req_mem);
    bus.stall = stall_v;
    bus.jump = jump_v;
    bus.jump_addr = fire_pend ? pend_q : fire_ex ? bus.ex_target : '0;
    bus.if_discard = (state_q == CTRL_DISCARD) & bus.if_busy;
  end
  // deferred target and the accepted flag that stops a held ex_jump from re-pulsing
  always_ff @(posedge clk) begin
    pend_q <= rst ? '0 : to_pend ? bus.ex_target : pend_q;
    acc_q <= rst ? 1'b0 : jump_v | (acc_q & bus.ex_jump & stall_v[2]);
  end
  pipe_ctrl_stall_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wd (
    .clk(clk),
    .rst(rst),
    .stalled(|stall_v),
    .timeout(bus.stall_timeout)
  );
`ifdef PIPE_CTRL_PERF_EN
  // free-running wrap-around performance counters
  always_ff @(posedge clk) begin
    bus.perf_stall_cycles <= rst ? '0 : bus.perf_stall_cycles + {31'd0, stall_v[0]};
    bus.perf_flushes <= rst ? '0 : bus.perf_flushes + {31'd0, jump_v};
  end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized stimulus against a rule-level reference model
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic m_pend, m_disc, m_held, m_to;
  logic [31:0] m_addr;
  int m_cnt;
  logic [5:0] exp_stall;
  logic exp_jump, exp_disc;
  logic [31:0] exp_addr;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] m_flush, m_stallc;
`endif
  pipe_ctrl_if bus();
  pipe_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic set_in(input logic ri, input logic rid, input logic rex, input logic rmem,
                        input logic ej, input logic [31:0] tgt, input logic busy);
    bus.req_if = ri;
    bus.req_id = rid;
    bus.req_ex = rex;
    bus.req_mem = rmem;
    bus.ex_jump = ej;
    bus.ex_target = tgt;
    bus.if_busy = busy;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    m_pend = 0; m_disc = 0; m_held = 0; m_to = 0; m_addr = 0; m_cnt = 0;
`ifdef PIPE_CTRL_PERF_EN
    m_flush = 0; m_stallc = 0;
`endif
  endtask

  task automatic model_eval;
    int n;
    logic take;
    n = bus.req_mem ? 5 : bus.req_ex ? 4 : bus.req_id ? 3 : bus.req_if ? 2 : 0;
    take = bus.ex_jump && !m_held && !m_pend && !rst;
    exp_stall = 6'((1 << n) - 1);
    exp_jump = 0;
    exp_addr = 0;
    if (m_pend) begin
      if (!bus.req_mem && !rst) begin exp_jump = 1; exp_addr = m_addr; end
    end else if (take && !bus.req_mem) begin
      exp_jump = 1;
      exp_addr = bus.ex_target;
      exp_stall = bus.req_ex ? 6'd15 : 6'd0;
    end
    exp_disc = m_disc && bus.if_busy;
  endtask

  task automatic model_update;
    logic take, held_n;
    take = bus.ex_jump && !m_held && !m_pend && !rst;
    if (rst) model_clear();
    else begin
      held_n = exp_jump || (m_held && bus.ex_jump && exp_stall[2]);
      if (m_pend) begin
        if (!bus.req_mem) begin m_pend = 0; m_disc = bus.if_busy; end
      end else if (take && bus.req_mem) begin
        m_pend = 1; m_addr = bus.ex_target; m_disc = 0;
      end else if (exp_jump) m_disc = bus.if_busy;
      else m_disc = m_disc && bus.if_busy;
      m_held = held_n;
      m_cnt = exp_stall != 0 ? m_cnt + 1 : 0;
      if (m_cnt >= TO) m_to = 1;
`ifdef PIPE_CTRL_PERF_EN
      m_flush = m_flush + {31'd0, exp_jump};
      m_stallc = m_stallc + {31'd0, exp_stall[0]};
`endif
    end
  endtask

  task automatic test_reset;
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 0;
    #1;
    checks += 5;
    if (bus.stall !== 6'd0) begin errors++; $display("FAIL reset stall got %b exp 000000", bus.stall); end
    if (bus.jump !== 1'b0) begin errors++; $display("FAIL reset jump got %b exp 0", bus.jump); end
    if (bus.jump_addr !== 32'd0) begin errors++; $display("FAIL reset jump_addr got %h exp 0", bus.jump_addr); end
    if (bus.if_discard !== 1'b0) begin errors++; $display("FAIL reset if_discard got %b exp 0", bus.if_discard); end
    if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL reset stall_timeout got %b exp 0", bus.stall_timeout); end
  endtask

  task automatic test_stall_prio;
    logic [5:0] e;
    for (int k = 0; k < 16; k++) begin
      set_in(k[0], k[1], k[2], k[3], 0, 0, 0);
      e = k[3] ? 6'b011111 : k[2] ? 6'b001111 : k[1] ? 6'b000111 : k[0] ? 6'b000011 : 6'b000000;
      checks++;
      if (bus.stall !== e) begin errors++; $display("FAIL prio req=%b stall got %b exp %b", 4'(k), bus.stall, e); end
    end
    step();
    set_in(0, 1, 0, 0, 0, 0, 0);
    checks += 2;
    if (bus.stall !== 6'b000111) begin errors++; $display("FAIL id_stall got %b exp 000111", bus.stall); end
    if (bus.jump !== 1'b0) begin errors++; $display("FAIL id_stall jump got %b exp 0", bus.jump); end
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.stall !== 6'd0) begin errors++; $display("FAIL id_release stall got %b exp 000000", bus.stall); end
    step();
  endtask

  task automatic test_jump;
    set_in(1, 1, 0, 0, 1, 32'h0000_1040, 0);
    checks += 3;
    if (bus.jump !== 1'b1) begin errors++; $display("FAIL jump pulse got %b exp 1", bus.jump); end
    if (bus.jump_addr !== 32'h1040) begin errors++; $display("FAIL jump addr got %h exp 00001040", bus.jump_addr); end
    if (bus.stall !== 6'd0) begin errors++; $display("FAIL jump flush_stall got %b exp 000000", bus.stall); end
    step();
    set_in(0, 0, 0, 0, 1, 32'h0000_1040, 0);
    checks++;
    if (bus.jump !== 1'b0) begin errors++; $display("FAIL jump held got %b exp 0", bus.jump); end
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_pend;
    for (int c = 0; c < 5; c++) begin
      set_in(0, 0, 0, c < 4, 1, 32'h2000, 0);
      checks++;
      if (bus.jump !== (c == 4)) begin errors++; $display("FAIL pend cyc %0d jump got %b exp %b", c, bus.jump, c == 4); end
      if (c == 4) begin
        checks++;
        if (bus.jump_addr !== 32'h2000) begin errors++; $display("FAIL pend addr got %h exp 00002000", bus.jump_addr); end
      end else begin
        checks++;
        if (bus.stall !== 6'b011111) begin errors++; $display("FAIL pend cyc %0d stall got %b exp 011111", c, bus.stall); end
      end
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.jump !== 1'b0) begin errors++; $display("FAIL pend after jump got %b exp 0", bus.jump); end
    step();
  endtask

  task automatic test_discard;
    set_in(0, 0, 0, 0, 1, 32'h3000, 1);
    checks += 2;
    if (bus.jump !== 1'b1) begin errors++; $display("FAIL disc jump got %b exp 1", bus.jump); end
    if (bus.if_discard !== 1'b0) begin errors++; $display("FAIL disc cyc0 if_discard got %b exp 0", bus.if_discard); end
    step();
    for (int c = 1; c < 6; c++) begin
      set_in(0, 0, 0, 0, 0, 0, c != 4);
      checks++;
      if (bus.if_discard !== (c < 4)) begin errors++; $display("FAIL disc cyc %0d if_discard got %b exp %b", c, bus.if_discard, c < 4); end
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_watchdog;
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 0;
    for (int n = 0; n < TO - 1; n++) begin set_in(0, 0, 1, 0, 0, 0, 0); step(); end
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL wd short got %b exp 0", bus.stall_timeout); end
    step();
    for (int n = 1; n <= TO + 2; n++) begin
      set_in(0, 0, 1, 0, 0, 0, 0);
      step();
      checks++;
      if (bus.stall_timeout !== (n >= TO)) begin errors++; $display("FAIL wd cyc %0d got %b exp %b", n, bus.stall_timeout, n >= TO); end
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    checks++;
    if (bus.stall_timeout !== 1'b1) begin errors++; $display("FAIL wd sticky got %b exp 1", bus.stall_timeout); end
  endtask

  task automatic test_reset_mid_pend;
    set_in(0, 0, 0, 1, 1, 32'h4000, 0);
    step();
    rst = 1;
    set_in(0, 0, 0, 1, 1, 32'h4000, 1);
    step();
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 1);
    checks += 5;
    if (bus.stall !== 6'd0) begin errors++; $display("FAIL rstpend stall got %b exp 000000", bus.stall); end
    if (bus.jump !== 1'b0) begin errors++; $display("FAIL rstpend jump got %b exp 0", bus.jump); end
    if (bus.jump_addr !== 32'd0) begin errors++; $display("FAIL rstpend addr got %h exp 0", bus.jump_addr); end
    if (bus.if_discard !== 1'b0) begin errors++; $display("FAIL rstpend if_discard got %b exp 0", bus.if_discard); end
    if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL rstpend timeout got %b exp 0", bus.stall_timeout); end
    step();
  endtask

  task automatic test_random;
    logic ej;
    ej = 0;
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 0;
    model_clear();
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 79) == 0;
      ej = ($urandom_range(0, 3) == 0) | (ej & ($urandom_range(0, 2) != 0));
      set_in($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0, ej, $urandom, $urandom_range(0, 1) == 1);
      model_eval();
      checks += 5;
      if (bus.stall !== exp_stall) begin errors++; $display("FAIL rand %0d stall got %b exp %b", i, bus.stall, exp_stall); end
      if (bus.jump !== exp_jump) begin errors++; $display("FAIL rand %0d jump got %b exp %b", i, bus.jump, exp_jump); end
      if (bus.jump_addr !== exp_addr) begin errors++; $display("FAIL rand %0d jump_addr got %h exp %h", i, bus.jump_addr, exp_addr); end
      if (bus.if_discard !== exp_disc) begin errors++; $display("FAIL rand %0d if_discard got %b exp %b", i, bus.if_discard, exp_disc); end
      if (bus.stall_timeout !== m_to) begin errors++; $display("FAIL rand %0d timeout got %b exp %b", i, bus.stall_timeout, m_to); end
      model_update();
      step();
    end
`ifdef PIPE_CTRL_PERF_EN
    checks += 2;
    if (bus.perf_flushes !== m_flush) begin errors++; $display("FAIL perf_flushes got %0d exp %0d", bus.perf_flushes, m_flush); end
    if (bus.perf_stall_cycles !== m_stallc) begin errors++; $display("FAIL perf_stall_cycles got %0d exp %0d", bus.perf_stall_cycles, m_stallc); end
`endif
  endtask

  initial begin
    test_reset();
    test_stall_prio();
    test_jump();
    test_pend();
    test_discard();
    test_watchdog();
    test_reset_mid_pend();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
